// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA raster constants and coordinate type.
// Default values describe the 640x480@60 Hz mode.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle between the raster generator, the color mapper
// and the DAC pins.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [7:0] Red_in;
  logic [7:0] Green_in;
  logic [7:0] Blue_in;
  coord_t     DrawX;
  coord_t     DrawY;
  logic       pixel_clk;
  logic       hs;
  logic       vs;
  logic       blank;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       vblank_start;

  modport master (
    input  Red_in, Green_in, Blue_in,
    output DrawX, DrawY, pixel_clk,
    output hs, vs, blank,
    output VGA_R, VGA_G, VGA_B,
    output vblank_start
  );

  modport slave (
    output Red_in, Green_in, Blue_in,
    input  DrawX, DrawY, pixel_clk,
    input  hs, vs, blank,
    input  VGA_R, VGA_G, VGA_B,
    input  vblank_start
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters plus a one-pixel registered output stage
// so sync, blank and color reach the DAC on the same edge.
module vga_timing_gen #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic             Clk,
  input  logic             Reset,
  vga_timing_gen_if.master vga
);
  import vga_pkg::*;

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t X_LAST = coord_t'(H_TOT - 1);
  localparam coord_t Y_LAST = coord_t'(V_TOT - 1);
  localparam coord_t X_VIS  = coord_t'(H_VISIBLE);
  localparam coord_t Y_VIS  = coord_t'(V_VISIBLE);
  localparam coord_t Y_VEND = coord_t'(V_VISIBLE - 1);
  localparam coord_t HS_ON  = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_OFF = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_ON  = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_OFF = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  logic       phase;
  logic       pixel_en;
  coord_t     x;
  coord_t     y;
  logic       x_end;
  logic       y_end;
  logic       visible;
  logic       hs_act;
  logic       vs_act;
  logic       hs_q;
  logic       vs_q;
  logic       blank_q;
  logic [7:0] r_q;
  logic [7:0] g_q;
  logic [7:0] b_q;

  assign pixel_en = phase;
  assign x_end    = (x == X_LAST);
  assign y_end    = (y == Y_LAST);
  assign visible  = (x < X_VIS) && (y < Y_VIS);
  assign hs_act   = (x >= HS_ON) && (x < HS_OFF);
  assign vs_act   = (y >= VS_ON) && (y < VS_OFF);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      phase   <= 1'b0;
      x       <= '0;
      y       <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      phase <= ~phase;
      if (pixel_en) begin
        x <= x_end ? '0 : x + 1'b1;
        if (x_end)
          y <= y_end ? '0 : y + 1'b1;
        // Stage samples the pre-increment coordinate.
        hs_q    <= ~hs_act;
        vs_q    <= ~vs_act;
        blank_q <= visible;
        r_q     <= visible ? vga.Red_in   : '0;
        g_q     <= visible ? vga.Green_in : '0;
        b_q     <= visible ? vga.Blue_in  : '0;
      end
    end
  end

  assign vga.DrawX     = x;
  assign vga.DrawY     = y;
  assign vga.pixel_clk = phase;
  assign vga.hs        = hs_q;
  assign vga.vs        = vs_q;
  assign vga.blank     = blank_q;
  assign vga.VGA_R     = r_q;
  assign vga.VGA_G     = g_q;
  assign vga.VGA_B     = b_q;

  // Last pixel of the last visible line; reset wins.
  assign vga.vblank_start = pixel_en & ~Reset & x_end
                          & (y == Y_VEND);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size instance for line timing, shrunken
// instance for whole frames, both against a raster model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   armed = 1'b0;
  int   run_id = 0;
  int   t = 0;
  int   errors = 0;
  int   checks = 0;
  int   cnt_vbs [3];
  int   cnt_vs  [3];

  always #5 clk = ~clk;

  vga_timing_gen_if big_if ();
  vga_timing_gen_if sml_if ();

  assign big_if.Red_in   = 8'hAA;
  assign big_if.Green_in = 8'h55;
  assign big_if.Blue_in  = 8'hFF;

  assign sml_if.Red_in   = sml_if.DrawX[7:0] ^ 8'h3C;
  assign sml_if.Green_in = sml_if.DrawY[7:0] + 8'h11;
  assign sml_if.Blue_in  = sml_if.DrawX[7:0]
                         + sml_if.DrawY[7:0];

  vga_timing_gen u_big (
    .Clk   (clk),
    .Reset (rst),
    .vga   (big_if.master)
  );

  vga_timing_gen #(
    .H_VISIBLE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_VISIBLE (12), .V_FP (3), .V_SYNC (2), .V_BP (4)
  ) u_sml (
    .Clk   (clk),
    .Reset (rst),
    .vga   (sml_if.master)
  );

  typedef struct {
    int ph, x, y, hs, vs, bl, r, g, b, vbs;
  } exp_t;

  // Clock edges since the last reset edge.
  always @(posedge clk) begin
    if (rst) t <= 0;
    else     t <= t + 1;
  end

  function automatic int col(int sel, int qx, int qy);
    case (sel)
      0: return (qx % 256) ^ 'h3C;
      1: return (qy + 'h11) % 256;
      default: return (qx + qy) % 256;
    endcase
  endfunction

  // Outputs after n edges: counters show pixel n/2,
  // registered stage shows the pixel before it.
  function automatic exp_t model(
    int n, bit r_now, bit grad,
    int hv, int hf, int hsw, int hb,
    int vv, int vf, int vsw, int vb);
    exp_t e;
    int ht, vt, p, q, qx, qy;
    bit vis;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p  = n / 2;
    e.ph = n % 2;
    e.x  = p % ht;
    e.y  = (p / ht) % vt;
    e.hs = 1; e.vs = 1; e.bl = 0;
    e.r  = 0; e.g  = 0; e.b  = 0;
    if (p > 0) begin
      q  = p - 1;
      qx = q % ht;
      qy = (q / ht) % vt;
      vis  = (qx < hv) && (qy < vv);
      e.hs = (qx >= hv + hf && qx < hv + hf + hsw) ? 0 : 1;
      e.vs = (qy >= vv + vf && qy < vv + vf + vsw) ? 0 : 1;
      e.bl = vis ? 1 : 0;
      if (vis) begin
        e.r = grad ? col(0, qx, qy) : 'hAA;
        e.g = grad ? col(1, qx, qy) : 'h55;
        e.b = grad ? col(2, qx, qy) : 'hFF;
      end
    end
    e.vbs = (!r_now && e.ph == 1 && e.x == ht - 1
             && e.y == vv - 1) ? 1 : 0;
    return e;
  endfunction

  task automatic cmp(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %0d want %0d",
               nm, t, act, exp);
    end
  endtask

  // Per-cycle check of both instances against the model.
  always @(negedge clk) begin
    exp_t eb, es;
    if (armed) begin
      eb = model(t, rst, 0, 640, 16, 96, 48, 480, 10, 2, 33);
      es = model(t, rst, 1, 16, 4, 6, 6, 12, 3, 2, 4);
      cmp("big.pclk",  int'(big_if.pixel_clk), eb.ph);
      cmp("big.x",     int'(big_if.DrawX), eb.x);
      cmp("big.y",     int'(big_if.DrawY), eb.y);
      cmp("big.hs",    int'(big_if.hs), eb.hs);
      cmp("big.vs",    int'(big_if.vs), eb.vs);
      cmp("big.blank", int'(big_if.blank), eb.bl);
      cmp("big.r",     int'(big_if.VGA_R), eb.r);
      cmp("big.g",     int'(big_if.VGA_G), eb.g);
      cmp("big.b",     int'(big_if.VGA_B), eb.b);
      cmp("big.vbs",   int'(big_if.vblank_start), eb.vbs);
      cmp("sml.pclk",  int'(sml_if.pixel_clk), es.ph);
      cmp("sml.x",     int'(sml_if.DrawX), es.x);
      cmp("sml.y",     int'(sml_if.DrawY), es.y);
      cmp("sml.hs",    int'(sml_if.hs), es.hs);
      cmp("sml.vs",    int'(sml_if.vs), es.vs);
      cmp("sml.blank", int'(sml_if.blank), es.bl);
      cmp("sml.r",     int'(sml_if.VGA_R), es.r);
      cmp("sml.g",     int'(sml_if.VGA_G), es.g);
      cmp("sml.b",     int'(sml_if.VGA_B), es.b);
      cmp("sml.vbs",   int'(sml_if.vblank_start), es.vbs);
      if (!rst && run_id > 0 && t < 1344) begin
        if (sml_if.vblank_start) cnt_vbs[run_id]++;
        if (!sml_if.vs)          cnt_vs[run_id]++;
      end
    end
  end

  task automatic wait_t(int target);
    int budget;
    budget = 0;
    while (t != target) begin
      @(posedge clk);
      #1;
      budget++;
      if (budget > 5000) begin
        errors++;
        $display("FAIL wait_t: t=%0d never reached %0d",
                 t, target);
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $fatal(1, "timeout");
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1 armed = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst.x",     int'(big_if.DrawX), 0);
    cmp("rst.hs",    int'(big_if.hs), 1);
    cmp("rst.blank", int'(big_if.blank), 0);
    cmp("rst.pclk",  int'(big_if.pixel_clk), 0);
    cmp("rst.r",     int'(big_if.VGA_R), 0);
    rst = 1'b0;
    run_id = 1;

    wait_t(1);
    cmp("t1.pclk", int'(big_if.pixel_clk), 1);
    cmp("t1.x",    int'(big_if.DrawX), 0);
    wait_t(2);
    cmp("t2.x",     int'(big_if.DrawX), 1);
    cmp("t2.pclk",  int'(big_if.pixel_clk), 0);
    cmp("t2.blank", int'(big_if.blank), 1);
    cmp("t2.r",     int'(big_if.VGA_R), 'hAA);
    cmp("t2.b",     int'(big_if.VGA_B), 'hFF);
    wait_t(766);
    cmp("vbs.pre",  int'(sml_if.vblank_start), 0);
    wait_t(767);
    cmp("vbs.on",   int'(sml_if.vblank_start), 1);
    wait_t(768);
    cmp("vbs.post", int'(sml_if.vblank_start), 0);
    wait_t(1281);
    cmp("x639.g",     int'(big_if.VGA_G), 'h55);
    wait_t(1282);
    cmp("x640.r",     int'(big_if.VGA_R), 0);
    cmp("x640.blank", int'(big_if.blank), 0);
    wait_t(1313);
    cmp("hs.pre", int'(big_if.hs), 1);
    wait_t(1314);
    cmp("hs.on",  int'(big_if.hs), 0);
    wait_t(1343);
    cmp("wrap.x0", int'(sml_if.DrawX), 31);
    cmp("wrap.y0", int'(sml_if.DrawY), 20);
    wait_t(1344);
    cmp("wrap.x1", int'(sml_if.DrawX), 0);
    cmp("wrap.y1", int'(sml_if.DrawY), 0);
    cmp("wrap.vbs", int'(sml_if.vblank_start), 0);
    wait_t(1505);
    cmp("hs.last", int'(big_if.hs), 0);
    wait_t(1506);
    cmp("hs.off",  int'(big_if.hs), 1);
    wait_t(1602);
    cmp("line2.y",     int'(big_if.DrawY), 1);
    cmp("line2.blank", int'(big_if.blank), 1);
    wait_t(1684);
    cmp("mid.x", int'(sml_if.DrawX), 10);
    cmp("mid.y", int'(sml_if.DrawY), 5);

    rst = 1'b1;
    @(posedge clk);
    #1;
    cmp("mrst.x",  int'(sml_if.DrawX), 0);
    cmp("mrst.y",  int'(sml_if.DrawY), 0);
    cmp("mrst.hs", int'(sml_if.hs), 1);
    cmp("mrst.vs", int'(sml_if.vs), 1);
    cmp("mrst.r",  int'(sml_if.VGA_R), 0);
    cmp("mrst.bx", int'(big_if.DrawX), 0);
    rst = 1'b0;
    run_id = 2;

    wait_t(2);
    cmp("rest.x", int'(sml_if.DrawX), 1);
    wait_t(1354);
    cmp("f1.vbs", cnt_vbs[1], 1);
    cmp("f1.vs",  cnt_vs[1], 128);
    cmp("f2.vbs", cnt_vbs[2], 1);
    cmp("f2.vs",  cnt_vs[2], 128);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
